// File: rtl/prbs8_pkg.sv
// +--------------------------------------------------------------------------+
// | prbs8_pkg : shared types, tap mask and next-bit function for PRBS8 logic  |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package prbs8_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] TAP = 8'b1100_1001;

  // r[7] is the newest bit; the result is the next bit of the sequence.
  function automatic logic prbs8_next_bit(input logic [7:0] r);
    return ^(r & TAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs8_err_ctr.sv
// +--------------------------------------------------------------------------+
// | prbs8_err_ctr : saturating up-counter with clear priority over increment  |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module prbs8_err_ctr #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {ERR_W{1'b1}})) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/prbs8_checker.sv
// +--------------------------------------------------------------------------+
// | prbs8_checker : self-synchronising serial PRBS8 checker with loss of sync |
// | Optional macro PRBS8_CHK_BITCNT_EN adds the 32-bit bit_cnt output.        |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int SYNC_LEN    = 16,
  parameter int LOSS_THRESH = 4,
  parameter int WIN         = 64,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS8_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int WBITS_W = $clog2(WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  state_e               state_q, state_d;
  logic [7:0]           r_q, r_d;
  logic [3:0]           fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WBITS_W-1:0]   wbits_q, wbits_d;
  logic [WERR_W-1:0]    werr_q, werr_d, werr_nx;
  logic                 err_pulse_q, err_pulse_d;
  logic                 sync_loss_q, sync_loss_d;
  logic                 pred, mism, err_inc;

  assign pred = prbs8_next_bit(r_q);
  assign mism = (din != pred);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    match_d     = match_q;
    wbits_d     = wbits_q;
    werr_d      = werr_q;
    werr_nx     = werr_q;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    err_inc     = 1'b0;
    if (en) begin
      unique case (state_q)
        SEARCH: begin
          r_d = {din, r_q[7:1]};
          if (fill_q != 4'd8) begin
            fill_d = fill_q + 4'd1;
          end else if (!mism && (r_q != 8'h00)) begin
            match_d = match_q + MATCH_W'(1);
            if (match_q + MATCH_W'(1) == MATCH_W'(SYNC_LEN)) begin
              state_d = LOCKED;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a bad bit never pollutes the history.
          r_d         = {pred, r_q[7:1]};
          err_pulse_d = mism;
          err_inc     = mism;
          werr_nx     = werr_q + WERR_W'(mism);
          if (werr_nx == WERR_W'(LOSS_THRESH)) begin
            state_d     = SEARCH;
            r_d         = '0;
            fill_d      = '0;
            match_d     = '0;
            wbits_d     = '0;
            werr_d      = '0;
            sync_loss_d = 1'b1;
          end else if (wbits_q == WBITS_W'(WIN - 1)) begin
            wbits_d = '0;
            werr_d  = '0;
          end else begin
            wbits_d = wbits_q + WBITS_W'(1);
            werr_d  = werr_nx;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      r_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      wbits_q     <= '0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      wbits_q     <= wbits_d;
      werr_q      <= werr_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;

  prbs8_err_ctr #(
    .ERR_W (ERR_W)
  ) u_err_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .clr_i (clr),
    .cnt_o (err_cnt)
  );

`ifdef PRBS8_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else if (clr) begin
      bit_cnt_q <= '0;
    end else if (en && (state_q == LOCKED)) begin
      bit_cnt_q <= bit_cnt_q + 32'd1;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs8_checker.sv
// +--------------------------------------------------------------------------+
// | tb_prbs8_checker : randomized self-checking bench for prbs8_checker       |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_prbs8_checker;
  import prbs8_pkg::*;

  localparam int WIN = 64;
  localparam int SZ  = 8192;

  logic clk = 1'b0;
  logic rst, en, din, clr;
  logic lk_a, ep_a, sl_a;
  logic [15:0] ec_a;
  logic lk_b, ep_b, sl_b;
  logic [3:0] ec_b;
`ifdef PRBS8_CHK_BITCNT_EN
  logic [31:0] bc_a, bc_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;
  bit [7:0] g;

  always #5 clk = ~clk;

  prbs8_checker u_dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(lk_a), .err_pulse(ep_a), .sync_loss(sl_a), .err_cnt(ec_a)
`ifdef PRBS8_CHK_BITCNT_EN
    , .bit_cnt(bc_a)
`endif
  );

  prbs8_checker #(.LOSS_THRESH(WIN + 1), .ERR_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(lk_b), .err_pulse(ep_b), .sync_loss(sl_b), .err_cnt(ec_b)
`ifdef PRBS8_CHK_BITCNT_EN
    , .bit_cnt(bc_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per instance, the stream since the last search start
  // obeys b[n] = b[n-8]^b[n-5]^b[n-2]^b[n-1]; once locked, expected bits
  // are extended from that recurrence and compared to what arrives.
  int          thr[2]  = '{4, WIN + 1};
  int          emax[2] = '{65535, 15};
  bit          s_m[2][SZ];
  int          n_m[2], run_m[2], lb_m[2], we_m[2], ec_m[2];
  bit          lk_m[2], ep_m[2], sl_m[2];
  logic [31:0] bc_m[2];

  function automatic int ix(input int n);
    return n & (SZ - 1);
  endfunction

  task automatic mdl_reset(input int k);
    n_m[k] = 0; run_m[k] = 0; lb_m[k] = 0; we_m[k] = 0; ec_m[k] = 0;
    lk_m[k] = 0; ep_m[k] = 0; sl_m[k] = 0; bc_m[k] = 0;
  endtask

  task automatic mdl_step(input int k, input bit e, input bit d, input bit c);
    bit p, nz;
    int t;
    ep_m[k] = 0;
    sl_m[k] = 0;
    if (e) begin
      t = n_m[k];
      if (!lk_m[k]) begin
        if (t >= 8) begin
          p  = s_m[k][ix(t-8)] ^ s_m[k][ix(t-5)] ^ s_m[k][ix(t-2)] ^ s_m[k][ix(t-1)];
          nz = 0;
          for (int j = 1; j <= 8; j++) nz |= s_m[k][ix(t-j)];
          run_m[k] = ((d == p) && nz) ? run_m[k] + 1 : 0;
        end
        s_m[k][ix(t)] = d;
        n_m[k] = t + 1;
        if (run_m[k] == 16) begin
          lk_m[k] = 1; lb_m[k] = 0; we_m[k] = 0;
        end
      end else begin
        p = s_m[k][ix(t-8)] ^ s_m[k][ix(t-5)] ^ s_m[k][ix(t-2)] ^ s_m[k][ix(t-1)];
        s_m[k][ix(t)] = p;
        n_m[k] = t + 1;
        bc_m[k] = bc_m[k] + 1;
        if (d != p) begin
          ep_m[k] = 1;
          we_m[k]++;
          if (!c && ec_m[k] < emax[k]) ec_m[k]++;
        end
        lb_m[k]++;
        if (we_m[k] == thr[k]) begin
          lk_m[k] = 0; sl_m[k] = 1; n_m[k] = 0; run_m[k] = 0;
        end else if (lb_m[k] == WIN) begin
          lb_m[k] = 0; we_m[k] = 0;
        end
      end
    end
    if (c) begin
      ec_m[k] = 0;
      bc_m[k] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) mdl_reset(k);
    end else begin
      for (int k = 0; k < 2; k++) mdl_step(k, en, din, clr);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("locked_a", lk_a, lk_m[0]);
      chk("err_pulse_a", ep_a, ep_m[0]);
      chk("sync_loss_a", sl_a, sl_m[0]);
      chk("err_cnt_a", ec_a, 32'(ec_m[0]));
      chk("locked_b", lk_b, lk_m[1]);
      chk("err_pulse_b", ep_b, ep_m[1]);
      chk("sync_loss_b", sl_b, sl_m[1]);
      chk("err_cnt_b", ec_b, 32'(ec_m[1]));
`ifdef PRBS8_CHK_BITCNT_EN
      chk("bit_cnt_a", bc_a, bc_m[0]);
      chk("bit_cnt_b", bc_b, bc_m[1]);
`endif
    end
  end

  task automatic tx(input bit e, input bit d, input bit c);
    @(negedge clk);
    en = e; din = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic gtx(input bit inv, input bit c);
    tx(1'b1, g[0] ^ inv, c);
    g = {prbs8_next_bit(g), g[7:1]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    g = 8'h01;
  endtask

  task automatic count_to_lock(input int maxb, output int at_a, output int at_b);
    at_a = -1;
    at_b = -1;
    for (int i = 1; i <= maxb; i++) begin
      gtx(1'b0, 1'b0);
      if (at_a < 0 && lk_a) at_a = i;
      if (at_b < 0 && lk_b) at_b = i;
      if (at_a > 0 && at_b > 0) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int la, lb, valid;
    bit seen;
    bit [7:0] gg;
    logic [10:0] seq;

    rst = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0; g = 8'h01;

    gg = 8'h01;
    for (int i = 0; i <= 10; i++) begin
      seq[10-i] = gg[0];
      gg = {prbs8_next_bit(gg), gg[7:1]};
    end
    chk("gen_first11", 32'(seq), 32'b100_0000_0110);

    do_reset();
    cmp_on = 1'b1;
    chk("rst_locked", lk_a, 0);
    chk("rst_err_cnt", ec_a, 0);
    chk("rst_err_pulse", ep_a, 0);
    chk("rst_sync_loss", sl_a, 0);

    // Clean stream: lock after exactly 24 bits, no errors across 500 bits.
    count_to_lock(40, la, lb);
    chk("lock_bits_a", la, 24);
    chk("lock_bits_b", lb, 24);
    for (int i = 0; i < 476; i++) gtx(1'b0, 1'b0);
    chk("clean_err_cnt", ec_a, 0);
    chk("clean_locked", lk_a, 1);

    // Single inverted bit.
    gtx(1'b1, 1'b0);
    chk("single_err_pulse", ep_a, 1);
    gtx(1'b0, 1'b0);
    chk("err_pulse_width", ep_a, 0);
    for (int i = 0; i < 100; i++) gtx(1'b0, 1'b0);
    chk("single_err_cnt", ec_a, 1);
    chk("single_locked", lk_a, 1);

    // Four errors in one window force loss on A only; A then re-locks.
    do_reset();
    count_to_lock(40, la, lb);
    for (int i = 0; i < 30; i++) gtx((i == 3) || (i == 10) || (i == 20) || (i == 29), 1'b0);
    chk("loss_sync_loss", sl_a, 1);
    chk("loss_locked", lk_a, 0);
    chk("loss_err_cnt", ec_a, 4);
    chk("loss_err_pulse", ep_a, 1);
    chk("noloss_locked_b", lk_b, 1);
    chk("noloss_err_cnt_b", ec_b, 4);
    count_to_lock(60, la, lb);
    chk("relock_bits_a", la, 24);

    // All-zero input never locks.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tx(1'b1, 1'b0, 1'b0);
      seen |= lk_a | lk_b;
    end
    chk("zero_no_lock", seen, 0);

    // Random en gaps: lock after 24 valid bits; held bits count once.
    do_reset();
    valid = 0;
    la = -1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        gtx(1'b0, 1'b0);
        valid++;
      end else begin
        tx(1'b0, din, 1'b0);
      end
      if (lk_a) begin
        la = valid;
        break;
      end
    end
    chk("rand_en_lock_valid", la, 24);
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) gtx(($urandom_range(0, 19) == 0), 1'b0);
      else tx(1'b0, $urandom_range(0, 1) == 1, 1'b0);
    end

    // Saturation on the 4-bit counter with loss disabled, then clr and rst.
    do_reset();
    count_to_lock(40, la, lb);
    for (int i = 0; i < 20; i++) gtx(1'b1, 1'b0);
    chk("sat_err_cnt_b", ec_b, 15);
    chk("sat_locked_b", lk_b, 1);
    gtx(1'b1, 1'b1);
    chk("clr_err_cnt_b", ec_b, 0);
    chk("clr_err_pulse_b", ep_b, 1);
    gtx(1'b1, 1'b0);
    chk("post_clr_err_cnt_b", ec_b, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked_b", lk_b, 0);
    chk("async_rst_err_cnt_b", ec_b, 0);
    chk("async_rst_err_pulse_b", ep_b, 0);
    chk("async_rst_sync_loss_b", sl_b, 0);
    chk("async_rst_err_cnt_a", ec_a, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
